// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the stall/flush controller and the five pipeline stages.
// The master side is the controller; the slave side is the pipeline.
interface pipeline_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             stallreq_if;
    logic             stallreq_id;
    logic             stallreq_ex;
    logic             stallreq_mem;
    logic             excp_valid;
    logic [31:0]      excp_new_pc;
    logic             dbg_halt_req;

    logic [5:0]       stall;
    logic             flush;
    logic [31:0]      new_pc;
    logic             dbg_halted;
    logic [CNT_W-1:0] stall_cycles;
    logic [15:0]      flush_count;
    logic             stall_timeout;

    modport master (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        input  excp_valid, excp_new_pc, dbg_halt_req,
        output stall, flush, new_pc, dbg_halted,
        output stall_cycles, flush_count, stall_timeout
    );

    modport slave (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        output excp_valid, excp_new_pc, dbg_halt_req,
        input  stall, flush, new_pc, dbg_halted,
        input  stall_cycles, flush_count, stall_timeout
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller: merges stage stall requests, exception flushes and
// debug halt into the pipeline stall vector, with perf counters and a stall watchdog.
module pipeline_ctrl #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 32
) (
    input  logic           clk,
    input  logic           rst,
    pipeline_ctrl_if.master bus
);
    typedef enum logic [2:0] {RUN, STALL, FLUSH, HALTING, HALTED} state_t;

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [1:0]       halt_cnt;
    logic             halted_q;
    logic [WD_W-1:0]  wd_cnt;
    logic             timeout_q;
    logic [CNT_W-1:0] stall_cnt;
    logic [15:0]      flush_cnt;

    logic [5:0]  req_stall;
    logic [5:0]  stall_c;
    logic        flush_c;
    logic [31:0] new_pc_c;
    logic        stall_any;

    // The oldest requesting stage freezes itself and everything younger.
    always_comb begin
        if (bus.stallreq_mem)     req_stall = 6'b011111;
        else if (bus.stallreq_ex) req_stall = 6'b001111;
        else if (bus.stallreq_id) req_stall = 6'b000111;
        else if (bus.stallreq_if) req_stall = 6'b000011;
        else                      req_stall = 6'b000000;
    end

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        stall_c  = 6'b000000;
        flush_c  = 1'b0;
        new_pc_c = 32'h0;
        if (!rst) begin
            case (state)
                RUN, STALL: begin
                    if (bus.excp_valid) begin
                        flush_c  = 1'b1;
                        new_pc_c = bus.excp_new_pc;
                    end else begin
                        stall_c = req_stall;
                    end
                end
                FLUSH:   stall_c = 6'b000001;
                HALTING: begin
                    if (bus.excp_valid) begin
                        flush_c  = 1'b1;
                        new_pc_c = bus.excp_new_pc;
                    end else begin
                        stall_c = 6'b000011;
                    end
                end
                HALTED:  stall_c = 6'b111111;
                default: stall_c = 6'b000000;
            endcase
        end
    end

    assign stall_any = (stall_c != 6'b000000);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; a later assignment in the same block overrides the default.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            halt_cnt <= 2'd0;
            halted_q <= 1'b0;
        end else begin
            halt_cnt <= 2'd0;
            case (state)
                RUN: begin
                    if (bus.excp_valid)            state <= FLUSH;
                    else if (req_stall != 6'b0)    state <= STALL;
                    else if (bus.dbg_halt_req)     state <= HALTING;
                end
                STALL: begin
                    if (bus.excp_valid)            state <= FLUSH;
                    else if (req_stall == 6'b0)    state <= RUN;
                end
                FLUSH: begin
                    state <= bus.dbg_halt_req ? HALTING : RUN;
                end
                HALTING: begin
                    if (bus.excp_valid) begin
                        state <= FLUSH;
                    end else if (halt_cnt == 2'd3) begin
                        state    <= HALTED;
                        halted_q <= 1'b1;
                    end else begin
                        halt_cnt <= halt_cnt + 2'd1;
                    end
                end
                HALTED: begin
                    if (!bus.dbg_halt_req) begin
                        state    <= RUN;
                        halted_q <= 1'b0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= 16'h0;
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (stall_any && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush_c && (flush_cnt != 16'hFFFF))
                flush_cnt <= flush_cnt + 16'd1;
            // A deliberate debug halt is not a hang, so it does not feed the watchdog.
            if (stall_any && (state != HALTED)) begin
                if (wd_cnt != WD_MAX)
                    wd_cnt <= wd_cnt + 1'b1;
                if (wd_cnt >= WD_LAST)
                    timeout_q <= 1'b1;
            end else begin
                wd_cnt <= '0;
            end
        end
    end

    assign bus.stall         = stall_c;
    assign bus.flush         = flush_c;
    assign bus.new_pc        = new_pc_c;
    assign bus.dbg_halted    = halted_q;
    assign bus.stall_cycles  = stall_cnt;
    assign bus.flush_count   = flush_cnt;
    assign bus.stall_timeout = timeout_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the live outputs.
module tb_pipeline_ctrl;
    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_ctrl #(.TIMEOUT_CYCLES(8), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       name;
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] new_pc;
        logic        halted;
        logic [31:0] sc;
        logic [15:0] fc;
        logic        to;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input string field,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s.%s: got %0h expected %0h", name, field, act, exp);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.name, "stall",  32'(bus.stall),         32'(e.stall));
            check(e.name, "flush",  32'(bus.flush),         32'(e.flush));
            check(e.name, "new_pc", bus.new_pc,             e.new_pc);
            check(e.name, "halted", 32'(bus.dbg_halted),    32'(e.halted));
            check(e.name, "s_cyc",  bus.stall_cycles,       e.sc);
            check(e.name, "f_cnt",  32'(bus.flush_count),   32'(e.fc));
            check(e.name, "tmo",    32'(bus.stall_timeout), 32'(e.to));
        end
    end

    // req = {mem, ex, id, if}
    task automatic drive(input logic [3:0] req, input logic excp,
                         input logic [31:0] epc, input logic halt);
        {bus.stallreq_mem, bus.stallreq_ex, bus.stallreq_id, bus.stallreq_if} = req;
        bus.excp_valid   = excp;
        bus.excp_new_pc  = epc;
        bus.dbg_halt_req = halt;
    endtask

    task automatic step(input string name, input logic [3:0] req, input logic excp,
                        input logic [31:0] epc, input logic halt,
                        input logic [5:0] e_stall, input logic e_flush,
                        input logic [31:0] e_pc, input logic e_halted,
                        input logic [31:0] e_sc, input logic [15:0] e_fc,
                        input logic e_to);
        exp_t e;
        drive(req, excp, epc, halt);
        e.name = name;   e.stall = e_stall; e.flush = e_flush; e.new_pc = e_pc;
        e.halted = e_halted; e.sc = e_sc; e.fc = e_fc; e.to = e_to;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        drive(4'b0000, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        step("rst1", 4'b0000, 0, 32'h0, 0, 6'b000000, 0, 32'h0, 0, 0, 0, 0);
        step("rst2", 4'b0000, 0, 32'h0, 0, 6'b000000, 0, 32'h0, 0, 0, 0, 0);
        rst = 1'b0;
        step("idle",     4'b0000, 0, 32'h0, 0, 6'b000000, 0, 32'h0, 0, 0, 0, 0);

        // Load-use stall escalating to a MEM stall, then release.
        step("id",       4'b0010, 0, 32'h0, 0, 6'b000111, 0, 32'h0, 0, 0, 0, 0);
        step("id_mem",   4'b1010, 0, 32'h0, 0, 6'b011111, 0, 32'h0, 0, 1, 0, 0);
        step("release",  4'b0000, 0, 32'h0, 0, 6'b000000, 0, 32'h0, 0, 2, 0, 0);
        step("run",      4'b0000, 0, 32'h0, 0, 6'b000000, 0, 32'h0, 0, 2, 0, 0);

        // Exception beats a simultaneous EX stall; held request resumes after FLUSH.
        step("excp",     4'b0100, 1, 32'h40, 0, 6'b000000, 1, 32'h40, 0, 2, 0, 0);
        step("flush_st", 4'b0100, 0, 32'h0,  0, 6'b000001, 0, 32'h0,  0, 2, 1, 0);
        step("ex_again", 4'b0100, 0, 32'h0,  0, 6'b001111, 0, 32'h0,  0, 3, 1, 0);
        step("ex_rel",   4'b0000, 0, 32'h0,  0, 6'b000000, 0, 32'h0,  0, 4, 1, 0);

        // Debug halt: four drain cycles, then full halt, then resume.
        step("halt_req", 4'b0000, 0, 32'h0, 1, 6'b000000, 0, 32'h0, 0, 4, 1, 0);
        for (int i = 0; i < 4; i++)
            step($sformatf("drain%0d", i), 4'b0000, 0, 32'h0, 1, 6'b000011, 0, 32'h0, 0,
                 32'(4 + i), 1, 0);
        step("halted",   4'b0000, 0, 32'h0, 1, 6'b111111, 0, 32'h0, 1, 8,  1, 0);
        step("halt_off", 4'b0000, 0, 32'h0, 0, 6'b111111, 0, 32'h0, 1, 9,  1, 0);
        step("resume",   4'b0000, 0, 32'h0, 0, 6'b000000, 0, 32'h0, 0, 10, 1, 0);

        // Watchdog: eight consecutive IF stalls latch the sticky timeout.
        for (int k = 0; k < 8; k++)
            step($sformatf("wd%0d", k), 4'b0001, 0, 32'h0, 0, 6'b000011, 0, 32'h0, 0,
                 32'(10 + k), 1, 0);
        step("wd_rel",   4'b0000, 0, 32'h0, 0, 6'b000000, 0, 32'h0, 0, 18, 1, 1);
        step("wd_stick", 4'b0000, 0, 32'h0, 0, 6'b000000, 0, 32'h0, 0, 18, 1, 1);

        // Exception arriving mid-drain still flushes.
        step("halt2",    4'b0000, 0, 32'h0,   1, 6'b000000, 0, 32'h0,   0, 18, 1, 1);
        step("drain2",   4'b0000, 0, 32'h0,   1, 6'b000011, 0, 32'h0,   0, 18, 1, 1);
        step("h_excp",   4'b0000, 1, 32'h100, 0, 6'b000000, 1, 32'h100, 0, 19, 1, 1);
        step("flush2",   4'b0000, 0, 32'h0,   0, 6'b000001, 0, 32'h0,   0, 19, 2, 1);
        step("run2",     4'b0000, 0, 32'h0,   0, 6'b000000, 0, 32'h0,   0, 20, 2, 1);

        // Reset asserted mid-drain clears everything, including the sticky flag.
        step("halt3",    4'b0000, 0, 32'h0, 1, 6'b000000, 0, 32'h0, 0, 20, 2, 1);
        step("drain3",   4'b0000, 0, 32'h0, 1, 6'b000011, 0, 32'h0, 0, 20, 2, 1);
        rst = 1'b1;
        drive(4'b0000, 1'b0, 32'h0, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("post_rst", 4'b0000, 0, 32'h0, 0, 6'b000000, 0, 32'h0, 0, 0, 0, 0);
        step("mem",      4'b1000, 0, 32'h0, 0, 6'b011111, 0, 32'h0, 0, 0, 0, 0);
        step("mem_rel",  4'b0000, 0, 32'h0, 0, 6'b000000, 0, 32'h0, 0, 1, 0, 0);

        @(negedge clk);
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, required 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
